// File: rtl/console_text_writer.sv
// Write-side controller for the text console character RAM: consumes a byte stream,
// tracks the cursor, handles CR/LF/BS and scrolls by advancing rowOffset and clearing a line.
module console_text_writer #(
    parameter int COLS   = 100,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              vgaClock,
    input  logic              reset,
    input  logic [7:0]        charIn,
    input  logic              charValid,
    output logic              charReady,
    input  logic              clearReq,
    output logic              busy,
    output logic [ADDR_W-1:0] addrWChar,
    output logic [7:0]        dataWChar,
    output logic              weChar,
    output logic [5:0]        rowOffset
);
    localparam int COL_W = $clog2(COLS);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TOTAL = COLS * ROWS;

    typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_WRITE, S_CLEAR_LINE} state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [5:0]        row_q, row_d;
    logic [5:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              scroll_q, scroll_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;

    // Physical row = (row + offset) mod ROWS, both operands already < ROWS.
    logic [6:0]        phys_sum;
    logic [5:0]        phys_row;
    logic [ADDR_W-1:0] row_base;
    logic              at_bottom;
    logic [5:0]        off_inc;

    always_comb begin
        phys_sum  = {1'b0, row_q} + {1'b0, off_q};
        phys_row  = (phys_sum >= 7'(ROWS)) ? 6'(phys_sum - 7'(ROWS)) : phys_sum[5:0];
        row_base  = ADDR_W'(phys_row) * ADDR_W'(COLS);
        at_bottom = (row_q == 6'(ROWS - 1));
        off_inc   = (off_q == 6'(ROWS - 1)) ? 6'd0 : off_q + 6'd1;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        scroll_d = scroll_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            S_CLEAR_ALL: begin
                col_d    = '0;
                row_d    = '0;
                off_d    = '0;
                scroll_d = 1'b0;
                if (cnt_q < CNT_W'(TOTAL)) begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(cnt_q);
                    data_d = 8'h20;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (clearReq) begin
                    state_d = S_CLEAR_ALL;
                    cnt_d   = '0;
                end else if (charValid) begin
                    if (charIn >= 8'h20 && charIn <= 8'h7E) begin
                        we_d    = 1'b1;
                        addr_d  = row_base + ADDR_W'(col_q);
                        data_d  = charIn;
                        state_d = S_WRITE;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d = '0;
                            if (at_bottom) begin
                                off_d    = off_inc;
                                scroll_d = 1'b1;
                            end else begin
                                row_d = row_q + 6'd1;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else if (charIn == 8'h0A) begin
                        col_d = '0;
                        if (at_bottom) begin
                            off_d   = off_inc;
                            cnt_d   = '0;
                            state_d = S_CLEAR_LINE;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else if (charIn == 8'h0D) begin
                        col_d = '0;
                    end else if (charIn == 8'h08 && col_q != '0) begin
                        col_d   = col_q - 1'b1;
                        we_d    = 1'b1;
                        addr_d  = row_base + ADDR_W'(col_q - 1'b1);
                        data_d  = 8'h20;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                scroll_d = 1'b0;
                cnt_d    = '0;
                state_d  = scroll_q ? S_CLEAR_LINE : S_IDLE;
            end
            S_CLEAR_LINE: begin
                // row_q sits at the bottom here, so row_base is the freshly exposed line.
                if (cnt_q < CNT_W'(COLS)) begin
                    we_d   = 1'b1;
                    addr_d = row_base + ADDR_W'(cnt_q);
                    data_d = 8'h20;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_CLEAR_ALL;
        endcase
    end

    always_ff @(posedge vgaClock) begin
        if (reset) begin
            state_q  <= S_CLEAR_ALL;
            col_q    <= '0;
            row_q    <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            scroll_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= 8'h20;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            scroll_q <= scroll_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign charReady = (state_q == S_IDLE) && !clearReq;
    assign busy      = (state_q != S_IDLE);
    assign weChar    = we_q;
    assign addrWChar = addr_q;
    assign dataWChar = data_q;
    assign rowOffset = off_q;
endmodule

// File: tb/tb_console_text_writer.sv
// Directed bench for console_text_writer: logs every RAM write and checks
// clears, cursor moves, wrap, scroll, backspace and clear/reset priority.
module tb_console_text_writer;
    localparam int ADDR_W = 13;

    logic              vgaClock = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        charIn = 8'h00;
    logic              charValid = 1'b0;
    logic              charReady;
    logic              clearReq = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] addrWChar;
    logic [7:0]        dataWChar;
    logic              weChar;
    logic [5:0]        rowOffset;

    int checks = 0;
    int failures = 0;
    logic [31:0] wq[$];

    console_text_writer #(.COLS(100), .ROWS(60), .ADDR_W(ADDR_W)) dut (
        .vgaClock (vgaClock),
        .reset    (reset),
        .charIn   (charIn),
        .charValid(charValid),
        .charReady(charReady),
        .clearReq (clearReq),
        .busy     (busy),
        .addrWChar(addrWChar),
        .dataWChar(dataWChar),
        .weChar   (weChar),
        .rowOffset(rowOffset)
    );

    always #5 vgaClock = ~vgaClock;

    always @(negedge vgaClock)
        if (weChar === 1'b1) wq.push_back({11'b0, addrWChar, dataWChar});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge vgaClock);
        while (charReady !== 1'b1 && n < bound) begin
            @(negedge vgaClock);
            n++;
        end
        if (charReady !== 1'b1) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_idle(20000);
        charIn    = b;
        charValid = 1'b1;
        @(posedge vgaClock);
        #1 charValid = 1'b0;
    endtask

    // Checks that the logged writes are n ascending addresses from base, all carrying d.
    task automatic check_run(input string tag, input int n, input int base, input logic [7:0] d);
        int bad = 0;
        check({tag, "_cnt"}, wq.size(), n);
        foreach (wq[i])
            if (wq[i][20:8] != 13'(base + i) || wq[i][7:0] != d) bad++;
        check({tag, "_seq"}, bad, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge vgaClock);
        #1 reset = 1'b0;
    endtask

    initial begin
        // 1: power-up clear
        pulse_reset();
        wq.delete();
        @(negedge vgaClock);
        check("rst_busy", busy, 1);
        check("rst_off", rowOffset, 0);
        wait_idle(7000);
        check_run("clr_all", 6000, 0, 8'h20);
        check("clr_ready", charReady, 1);
        check("clr_off", rowOffset, 0);

        // 2: first characters and handshake latency
        wq.delete();
        send(8'h41);
        @(negedge vgaClock);
        check("a_we", weChar, 1);
        check("a_addr", addrWChar, 0);
        check("a_data", dataWChar, 8'h41);
        check("a_rdy_n1", charReady, 0);
        @(negedge vgaClock);
        check("a_we_off", weChar, 0);
        check("a_rdy_n2", charReady, 1);
        wq.delete();
        send(8'h42);
        wait_idle(10);
        check_run("b_at1", 1, 1, 8'h42);

        // 3: fill row 0 and wrap to row 1
        send(8'h0D);
        wait_idle(10);
        wq.delete();
        for (int i = 0; i < 100; i++) send(8'h42);
        wait_idle(10);
        check_run("row0", 100, 0, 8'h42);
        wq.delete();
        send(8'h43);
        wait_idle(10);
        check_run("wrap", 1, 100, 8'h43);

        // 4: scroll from the bottom row
        wq.delete();
        for (int i = 0; i < 58; i++) send(8'h0A);
        wait_idle(10);
        check("lf_nowrite", wq.size(), 0);
        check("lf_off0", rowOffset, 0);
        send(8'h0A);
        @(negedge vgaClock);
        check("scr_busy", busy, 1);
        wait_idle(200);
        check("scr_off", rowOffset, 1);
        check_run("scr_line", 100, 0, 8'h20);
        wq.delete();
        send(8'h44);
        wait_idle(10);
        check_run("scr_d", 1, 0, 8'h44);

        // 5: backspace
        send(8'h0D);
        wait_idle(10);
        wq.delete();
        send(8'h08);
        @(negedge vgaClock);
        check("bs0_rdy", charReady, 1);
        check("bs0_nowrite", wq.size(), 0);
        send(8'h58);
        wait_idle(10);
        check_run("bs_x", 1, 0, 8'h58);
        wq.delete();
        send(8'h08);
        wait_idle(10);
        check_run("bs_sp", 1, 0, 8'h20);
        wq.delete();
        send(8'h59);
        wait_idle(10);
        check_run("bs_col0", 1, 0, 8'h59);

        // 6a: clearReq beats a same-cycle byte
        wait_idle(10);
        clearReq  = 1'b1;
        charIn    = 8'h5A;
        charValid = 1'b1;
        #1 check("cr_rdy", charReady, 0);
        @(posedge vgaClock);
        #1 begin clearReq = 1'b0; charValid = 1'b0; end
        wq.delete();
        @(negedge vgaClock);
        check("cr_busy", busy, 1);
        wait_idle(7000);
        check_run("cr_clr", 6000, 0, 8'h20);
        check("cr_off", rowOffset, 0);
        wq.delete();
        send(8'h31);
        wait_idle(10);
        check_run("cr_home", 1, 0, 8'h31);

        // 6b: reset during a line clear restarts the full clear
        for (int i = 0; i < 60; i++) send(8'h0A);
        repeat (10) @(negedge vgaClock);
        check("ml_busy", busy, 1);
        check("ml_off", rowOffset, 1);
        pulse_reset();
        wq.delete();
        @(negedge vgaClock);
        check("ml_rst_off", rowOffset, 0);
        wait_idle(7000);
        check_run("ml_clr", 6000, 0, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
